// File: rtl/mul_exec_unit.sv
// rtl/mul_exec_unit.sv - iterative shift-add multiplier for the execute stage (MUL_ACCUM_EN adds MLA addend)
module mul_exec_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             StartE,
    input  logic             FlushE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [3:0]       FlagsE,
`ifdef MUL_ACCUM_EN
    input  logic [WIDTH-1:0] AccE,
`endif
    output logic [WIDTH-1:0] ResultE,
    output logic [3:0]       ALUFlagsOut,
    output logic             DoneE,
    output logic             StallMulE
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       cv_reg;
    logic [WIDTH-1:0] partial;
    logic             issue;
    logic             unused_flags;

    // N and Z are recomputed from the product; C and V pass through untouched.
    assign unused_flags = ^FlagsE[3:2];

    assign issue     = (state == IDLE) && StartE && !FlushE;
    assign StallMulE = RESET && (issue || (state == RUN));

    // a_reg is pre-shifted each cycle, so the low slice of b_reg selects shifted copies of A.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (b_reg[i]) begin
                partial = partial + (a_reg << i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            cv_reg      <= '0;
            ResultE     <= '0;
            ALUFlagsOut <= '0;
            DoneE       <= 1'b0;
        end else begin
            DoneE <= 1'b0;
            if (FlushE) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (StartE) begin
                            a_reg  <= SrcAE;
                            b_reg  <= SrcBE;
                            cv_reg <= FlagsE[1:0];
`ifdef MUL_ACCUM_EN
                            acc    <= AccE;
`else
                            acc    <= '0;
`endif
                            count  <= '0;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        acc   <= acc + partial;
                        a_reg <= a_reg << BITS_PER_CYCLE;
                        b_reg <= b_reg >> BITS_PER_CYCLE;
                        if (count == CW'(N - 1)) begin
                            count <= '0;
                            state <= DONE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    DONE: begin
                        ResultE     <= acc;
                        ALUFlagsOut <= {acc[WIDTH-1], (acc == '0), cv_reg};
                        DoneE       <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_exec_unit.sv
// tb/tb_mul_exec_unit.sv - self-checking bench for mul_exec_unit against a timeline model
module tb_mul_exec_unit;

    localparam int W  = 32;
    localparam int N1 = 32;

    logic          CLK;
    logic          RESET;
    logic          StartE;
    logic          FlushE;
    logic [W-1:0]  SrcAE;
    logic [W-1:0]  SrcBE;
    logic [3:0]    FlagsE;
    logic [W-1:0]  AccE;
    logic [W-1:0]  ResultE;
    logic [3:0]    ALUFlagsOut;
    logic          DoneE;
    logic          StallMulE;
    logic [W-1:0]  Result4;
    logic [3:0]    Flags4;
    logic          Done4;
    logic          Stall4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mul_exec_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .CLK(CLK), .RESET(RESET), .StartE(StartE), .FlushE(FlushE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .FlagsE(FlagsE),
`ifdef MUL_ACCUM_EN
        .AccE(AccE),
`endif
        .ResultE(ResultE), .ALUFlagsOut(ALUFlagsOut), .DoneE(DoneE), .StallMulE(StallMulE)
    );

    mul_exec_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .StartE(StartE), .FlushE(FlushE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .FlagsE(FlagsE),
`ifdef MUL_ACCUM_EN
        .AccE(AccE),
`endif
        .ResultE(Result4), .ALUFlagsOut(Flags4), .DoneE(Done4), .StallMulE(Stall4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: an op is a countdown of N+1 edges from issue to the result edge.
    bit           busy;
    int           rem;
    logic [W-1:0] pa, pb, pacc;
    logic [1:0]   pcv;
    logic [W-1:0] m_res;
    logic [3:0]   m_flags;
    bit           m_done;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy = 0; rem = 0; m_res = '0; m_flags = '0; m_done = 0;
        end else begin
            m_done = 0;
            if (FlushE) begin
                busy = 0;
            end else if (busy) begin
                rem--;
                if (rem == 0) begin
                    logic [63:0] full;
                    busy    = 0;
                    full    = 64'(pa) * 64'(pb) + 64'(pacc);
                    m_res   = full[W-1:0];
                    m_flags = {m_res[W-1], m_res == '0, pcv};
                    m_done  = 1;
                end
            end else if (StartE) begin
                busy = 1;
                rem  = N1 + 1;
                pa   = SrcAE;
                pb   = SrcBE;
                pcv  = FlagsE[1:0];
`ifdef MUL_ACCUM_EN
                pacc = AccE;
`else
                pacc = '0;
`endif
            end
        end
    end

    always @(negedge CLK) begin
        logic exp_stall;
        exp_stall = RESET && ((!busy && StartE && !FlushE) || (busy && rem > 1));
        check("cmp_done",   W'(DoneE),       W'(m_done));
        check("cmp_result", ResultE,         m_res);
        check("cmp_flags",  W'(ALUFlagsOut), W'(m_flags));
        check("cmp_stall",  W'(StallMulE),   W'(exp_stall));
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] f, input logic [W-1:0] c);
        @(posedge CLK); #2;
        SrcAE = a; SrcBE = b; FlagsE = f; AccE = c; StartE = 1'b1;
        @(posedge CLK); #2;
        StartE = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DoneE) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_dones(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            if (DoneE) n++;
        end
    endtask

    initial begin
        int lat, n, d1, d4, t1, t2;
        RESET = 1'b0; StartE = 1'b0; FlushE = 1'b0;
        SrcAE = '0; SrcBE = '0; FlagsE = '0; AccE = '0;
        #1 StartE = 1'b1;
        #1;
        check("reset_result", ResultE, '0);
        check("reset_flags",  W'(ALUFlagsOut), '0);
        check("reset_done",   W'(DoneE), '0);
        check("reset_stall",  W'(StallMulE), '0);
        StartE = 1'b0;
        #20 RESET = 1'b1;

        issue(7, 6, 4'b0011, 0);
        wait_done(lat);
        check("t2_latency", W'(lat), 33);
        check("t2_result",  ResultE, 42);
        check("t2_flags",   W'(ALUFlagsOut), W'(4'b0011));

        issue(32'hFFFF_FFFF, 2, 4'b0000, 0);
        wait_done(lat);
        check("t3_neg_result", ResultE, 32'hFFFF_FFFE);
        check("t3_neg_flags",  W'(ALUFlagsOut), W'(4'b1000));
        issue(0, 5, 4'b0010, 0);
        wait_done(lat);
        check("t3_zero_latency", W'(lat), 33);
        check("t3_zero_result",  ResultE, 0);
        check("t3_zero_flags",   W'(ALUFlagsOut), W'(4'b0110));

        issue(9, 9, 4'b0000, 0);
        repeat (5) @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("t1_async_result", ResultE, '0);
        check("t1_async_flags",  W'(ALUFlagsOut), '0);
        check("t1_async_stall",  W'(StallMulE), '0);
        @(posedge CLK); #3 RESET = 1'b1;
        count_dones(40, n);
        check("t1_no_done", W'(n), 0);

        issue(5, 5, 4'b0000, 0);
        wait_done(lat);
        check("t4_pre_result", ResultE, 25);
        issue(3, 3, 4'b0000, 0);
        repeat (9) @(posedge CLK);
        #2 FlushE = 1'b1;
        @(posedge CLK); #2 FlushE = 1'b0;
        @(negedge CLK);
        check("t4_stall_drop", W'(StallMulE), 0);
        check("t4_hold_result", ResultE, 25);
        count_dones(40, n);
        check("t4_no_done", W'(n), 0);
        issue(11, 13, 4'b0001, 0);
        wait_done(lat);
        check("t4_next_result", ResultE, 143);

        @(posedge CLK); #2 StartE = 1'b1; FlushE = 1'b1;
        @(negedge CLK);
        check("flush_wins_stall", W'(StallMulE), 0);
        @(posedge CLK); #2 StartE = 1'b0; FlushE = 1'b0;
        @(negedge CLK);
        check("flush_wins_idle", W'(StallMulE), 0);

        SrcAE = 2; SrcBE = 21; FlagsE = 4'b0000;
        @(posedge CLK); #2 StartE = 1'b1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 200 && t2 < 0; i++) begin
            @(negedge CLK);
            if (DoneE) begin
                if (t1 < 0) t1 = cyc; else t2 = cyc;
            end
        end
        check("t5_spacing", W'(t2 - t1), 34);
        check("t5_result",  ResultE, 42);
        #2 StartE = 1'b0;
        repeat (40) @(posedge CLK);

        issue(7, 6, 4'b0011, 0);
        d1 = -1; d4 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (Done4 && d4 < 0) d4 = i;
            if (DoneE && d1 < 0) d1 = i;
        end
        check("bpc4_latency", W'(d4), 9);
        check("bpc4_result",  Result4, 42);
        check("bpc1_latency", W'(d1), 33);

`ifdef MUL_ACCUM_EN
        issue(3, 4, 4'b0000, 32'hFFFF_FFF4);
        wait_done(lat);
        check("t6_result", ResultE, 0);
        check("t6_flags",  W'(ALUFlagsOut), W'(4'b0100));
`endif

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
